// File: rtl/lzs_decode_core_if.sv
// Stream and byte-output handshake bundle for the LZS decode core.
// master: the decoder side (consumes the bit window, produces bytes).
// slave:  the surrounding aligner / output FIFO side.
interface lzs_decode_core_if;
    logic [12:0] stream_data;
    logic        stream_valid;
    logic [3:0]  stream_width;
    logic        stream_ack;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;

    modport master (
        input  stream_data, stream_valid, out_ready,
        output stream_width, stream_ack, out_data, out_valid
    );

    modport slave (
        output stream_data, stream_valid, out_ready,
        input  stream_width, stream_ack, out_data, out_valid
    );
endinterface

// File: rtl/lzs_decode_core.sv
// LZS decode core: parses the MSB-first LZS token stream from a 13-bit
// window, expands matches from an internal history buffer and emits bytes
// through a single-entry valid/ready output slot.
module lzs_decode_core #(
    parameter int HIST_AW = 11,
    parameter int LEN_W   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ce_decode,
    lzs_decode_core_if.master     bus,
    output logic                  all_end,
    output logic                  err,
    output logic [31:0]           byte_cnt
);
    localparam int DEPTH = 1 << HIST_AW;
    localparam logic [HIST_AW:0] HIST_FULL = {1'b1, {HIST_AW{1'b0}}};

    typedef enum logic [3:0] {
        S_IDLE, S_TOKEN, S_LEN1, S_LEN2, S_LENX, S_COPY, S_DRAIN, S_END, S_ERR
    } state_t;

    state_t               state;
    logic [7:0]           hist [DEPTH];
    logic [HIST_AW-1:0]   wr_ptr;
    logic [HIST_AW:0]     hist_cnt;
    logic [10:0]          offset;
    logic [LEN_W-1:0]     len;
    logic [LEN_W-1:0]     len_acc;

    // Output slot (stage 1): byte produced in stage 0 becomes visible here.
    logic                 vld_p1;
    logic [7:0]           out_data_p1;

    // Stage 0: token decode and byte production (combinational).
    logic                 slot_free;
    logic                 produce_p0;
    logic [7:0]           prod_byte_p0;
    logic                 ack;
    logic [3:0]           width;
    logic [12:0]          d;
    logic                 tok_lit, tok_end, tok_off7, tok_off11;
    logic [10:0]          tok_off;
    logic                 off_bad;
    logic [LEN_W:0]       len_sum;
    logic                 len_ovf;
    logic [HIST_AW-1:0]   rd_addr;
    logic [7:0]           hist_rd;

    assign d         = bus.stream_data;
    assign slot_free = ~vld_p1 | bus.out_ready;

    assign tok_lit   = ~d[12];
    assign tok_end   = (d[12:4] == 9'b110000000);
    assign tok_off7  = (d[12:11] == 2'b11) & ~tok_end;
    assign tok_off11 = (d[12:11] == 2'b10);
    assign tok_off   = tok_off7 ? {4'b0000, d[10:4]} : d[10:0];
    // An offset reaching beyond the bytes written so far cannot be resolved.
    assign off_bad   = (tok_off11 & (d[10:0] == 11'd0)) |
                       ({1'b0, tok_off} > 12'(hist_cnt));

    // Extension nibble added to the running length; carry out means overflow.
    assign len_sum   = {1'b0, len_acc} + {{(LEN_W-3){1'b0}}, d[12:9]};
    assign len_ovf   = len_sum[LEN_W];

    // Read-before-write: an offset of exactly DEPTH maps onto wr_ptr itself,
    // which still holds the oldest byte at this edge.
    assign rd_addr   = wr_ptr - offset[HIST_AW-1:0];
    assign hist_rd   = hist[rd_addr];

    // Stream consume and byte-production decisions for the current state.
    always_comb begin
        ack          = 1'b0;
        width        = 4'd0;
        produce_p0   = 1'b0;
        prod_byte_p0 = 8'd0;
        case (state)
            S_TOKEN: begin
                if (bus.stream_valid) begin
                    if (tok_lit) begin
                        if (slot_free) begin
                            ack          = 1'b1;
                            width        = 4'd9;
                            produce_p0   = 1'b1;
                            prod_byte_p0 = d[11:4];
                        end
                    end else if (tok_end) begin
                        ack   = 1'b1;
                        width = 4'd9;
                    end else if (!off_bad) begin
                        ack   = 1'b1;
                        width = tok_off11 ? 4'd13 : 4'd9;
                    end
                end
            end
            S_LEN1, S_LEN2: begin
                if (bus.stream_valid) begin
                    ack   = 1'b1;
                    width = 4'd2;
                end
            end
            S_LENX: begin
                if (bus.stream_valid && !len_ovf) begin
                    ack   = 1'b1;
                    width = 4'd4;
                end
            end
            S_COPY: begin
                if (slot_free) begin
                    produce_p0   = 1'b1;
                    prod_byte_p0 = hist_rd;
                end
            end
            default: ;
        endcase
    end

    assign bus.stream_ack   = ack;
    assign bus.stream_width = width;
    assign bus.out_valid    = vld_p1;
    assign bus.out_data     = out_data_p1;

    // History buffer write; contents need no reset.
    always_ff @(posedge clk) begin
        if (produce_p0)
            hist[wr_ptr] <= prod_byte_p0;
    end

    // Parser FSM, output slot, history bookkeeping and status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            vld_p1      <= 1'b0;
            out_data_p1 <= 8'd0;
            all_end     <= 1'b0;
            err         <= 1'b0;
            byte_cnt    <= 32'd0;
            hist_cnt    <= '0;
            wr_ptr      <= '0;
            offset      <= 11'd0;
            len         <= '0;
            len_acc     <= '0;
        end else begin
            if (produce_p0) begin
                vld_p1      <= 1'b1;
                out_data_p1 <= prod_byte_p0;
                wr_ptr      <= wr_ptr + HIST_AW'(1);
                if (hist_cnt != HIST_FULL)
                    hist_cnt <= hist_cnt + (HIST_AW+1)'(1);
            end else if (bus.out_ready) begin
                vld_p1 <= 1'b0;
            end

            if (vld_p1 && bus.out_ready)
                byte_cnt <= byte_cnt + 32'd1;

            case (state)
                S_IDLE: begin
                    all_end <= 1'b0;
                    if (ce_decode) begin
                        hist_cnt <= '0;
                        wr_ptr   <= '0;
                        byte_cnt <= 32'd0;
                        err      <= 1'b0;
                        state    <= S_TOKEN;
                    end
                end
                S_TOKEN: begin
                    if (bus.stream_valid && !tok_lit) begin
                        if (tok_end) begin
                            state <= S_DRAIN;
                        end else if (off_bad) begin
                            err   <= 1'b1;
                            state <= S_ERR;
                        end else begin
                            offset <= tok_off;
                            state  <= S_LEN1;
                        end
                    end
                end
                S_LEN1: begin
                    if (bus.stream_valid) begin
                        case (d[12:11])
                            2'b00:   begin len <= LEN_W'(2); state <= S_COPY; end
                            2'b01:   begin len <= LEN_W'(3); state <= S_COPY; end
                            2'b10:   begin len <= LEN_W'(4); state <= S_COPY; end
                            default: state <= S_LEN2;
                        endcase
                    end
                end
                S_LEN2: begin
                    if (bus.stream_valid) begin
                        case (d[12:11])
                            2'b00:   begin len <= LEN_W'(5); state <= S_COPY; end
                            2'b01:   begin len <= LEN_W'(6); state <= S_COPY; end
                            2'b10:   begin len <= LEN_W'(7); state <= S_COPY; end
                            default: begin len_acc <= LEN_W'(8); state <= S_LENX; end
                        endcase
                    end
                end
                S_LENX: begin
                    if (bus.stream_valid) begin
                        if (len_ovf) begin
                            err   <= 1'b1;
                            state <= S_ERR;
                        end else if (d[12:9] == 4'hF) begin
                            len_acc <= len_sum[LEN_W-1:0];
                        end else begin
                            len   <= len_sum[LEN_W-1:0];
                            state <= S_COPY;
                        end
                    end
                end
                S_COPY: begin
                    if (slot_free) begin
                        len <= len - LEN_W'(1);
                        if (len == LEN_W'(1))
                            state <= S_TOKEN;
                    end
                end
                S_DRAIN: begin
                    if (slot_free) begin
                        all_end <= 1'b1;
                        state   <= S_END;
                    end
                end
                S_END: begin
                    if (!ce_decode) begin
                        all_end <= 1'b0;
                        state   <= S_IDLE;
                    end
                end
                S_ERR: begin
                    if (!ce_decode)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lzs_decode_core.sv
// Directed bench for lzs_decode_core: a large-history instance (dut0) and a
// 16-byte-history instance (dut1), each fed from its own bit buffer.
module tb_lzs_decode_core;
    logic        clk = 1'b0;
    logic        rst;
    logic        ce0, ce1;
    logic        all_end0, all_end1, err0, err1;
    logic [31:0] bc0, bc1;

    always #5 clk = ~clk;

    lzs_decode_core_if if0();
    lzs_decode_core_if if1();

    lzs_decode_core #(.HIST_AW(11), .LEN_W(16)) dut0 (
        .clk(clk), .rst(rst), .ce_decode(ce0), .bus(if0),
        .all_end(all_end0), .err(err0), .byte_cnt(bc0)
    );

    lzs_decode_core #(.HIST_AW(4), .LEN_W(16)) dut1 (
        .clk(clk), .rst(rst), .ce_decode(ce1), .bus(if1),
        .all_end(all_end1), .err(err1), .byte_cnt(bc1)
    );

    logic       bitbuf [2][2048];
    int         nb [2];
    int         rp [2];
    int         checks = 0;
    int         errors = 0;
    logic [7:0] outq0 [$];
    logic [7:0] outq1 [$];
    int         ackq0 [$];
    int         ackq1 [$];
    logic       stalled0 = 1'b0;
    logic [7:0] held0 = 8'd0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic upd();
        logic [12:0] w;
        for (int k = 0; k < 2; k++) begin
            w = '0;
            for (int i = 0; i < 13; i++)
                if (rp[k] + i < nb[k]) w[12-i] = bitbuf[k][rp[k]+i];
            if (k == 0) begin
                if0.stream_data  = w;
                if0.stream_valid = (rp[k] < nb[k]);
            end else begin
                if1.stream_data  = w;
                if1.stream_valid = (rp[k] < nb[k]);
            end
        end
    endtask

    task automatic push(input int k, input logic [31:0] val, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            bitbuf[k][nb[k]] = val[i];
            nb[k]++;
        end
    endtask

    task automatic lit(input int k, input logic [7:0] b);
        push(k, 0, 1);
        push(k, {24'd0, b}, 8);
    endtask

    task automatic endm(input int k);
        push(k, 32'h180, 9);
    endtask

    task automatic off7(input int k, input int o);
        push(k, 3, 2);
        push(k, o, 7);
    endtask

    task automatic off11(input int k, input int o);
        push(k, 2, 2);
        push(k, o, 11);
    endtask

    task automatic lenc(input int k, input int l);
        int r;
        if (l <= 4) begin
            push(k, l - 2, 2);
        end else if (l <= 7) begin
            push(k, 3, 2);
            push(k, l - 5, 2);
        end else begin
            push(k, 3, 2);
            push(k, 3, 2);
            r = l - 8;
            while (r >= 15) begin
                push(k, 15, 4);
                r -= 15;
            end
            push(k, r, 4);
        end
    endtask

    task automatic clear(input int k);
        nb[k] = 0;
        rp[k] = 0;
        if (k == 0) begin
            outq0.delete();
            ackq0.delete();
        end else begin
            outq1.delete();
            ackq1.delete();
        end
        upd();
    endtask

    // One clock: sample before the edge, advance stream pointers after it.
    task automatic tick();
        int w0, w1;
        @(negedge clk);
        w0 = 0;
        w1 = 0;
        if (if0.stream_ack) begin
            w0 = int'(if0.stream_width);
            ackq0.push_back(w0);
        end
        if (stalled0) begin
            chk("hold_valid", {31'd0, if0.out_valid}, 32'd1);
            chk("hold_data", {24'd0, if0.out_data}, {24'd0, held0});
        end
        if (if0.out_valid && if0.out_ready) outq0.push_back(if0.out_data);
        stalled0 = if0.out_valid && !if0.out_ready;
        held0    = if0.out_data;
        if (if1.stream_ack) begin
            w1 = int'(if1.stream_width);
            ackq1.push_back(w1);
        end
        if (if1.out_valid && if1.out_ready) outq1.push_back(if1.out_data);
        @(posedge clk);
        #1;
        rp[0] += w0;
        rp[1] += w1;
        upd();
    endtask

    task automatic wait_end0(input int bound);
        for (int i = 0; i < bound && !all_end0; i++) tick();
        chk("all_end_reached", {31'd0, all_end0}, 32'd1);
    endtask

    initial begin
        int exp2 [7];
        int nbad;
        int nack;
        logic [7:0] exp3 [7];

        rst = 1'b1;
        ce0 = 1'b0;
        ce1 = 1'b0;
        if0.out_ready = 1'b1;
        if1.out_ready = 1'b1;
        nb[0] = 0; nb[1] = 0; rp[0] = 0; rp[1] = 0;
        upd();
        tick();
        tick();
        chk("rst_out_valid", {31'd0, if0.out_valid}, 32'd0);
        chk("rst_out_data", {24'd0, if0.out_data}, 32'd0);
        chk("rst_ack", {31'd0, if0.stream_ack}, 32'd0);
        chk("rst_width", {28'd0, if0.stream_width}, 32'd0);
        chk("rst_all_end", {31'd0, all_end0}, 32'd0);
        chk("rst_err", {31'd0, err0}, 32'd0);
        chk("rst_byte_cnt", bc0, 32'd0);
        rst = 1'b0;
        tick();

        // Two literals and an end marker.
        clear(0);
        lit(0, 8'h41); lit(0, 8'h42); endm(0);
        upd();
        ce0 = 1'b1;
        wait_end0(40);
        chk("t1_nbytes", outq0.size(), 2);
        chk("t1_byte0", {24'd0, outq0[0]}, 32'h41);
        chk("t1_byte1", {24'd0, outq0[1]}, 32'h42);
        chk("t1_nacks", ackq0.size(), 3);
        for (int i = 0; i < ackq0.size() && i < 3; i++) chk("t1_width", ackq0[i], 9);
        chk("t1_byte_cnt", bc0, 32'd2);
        ce0 = 1'b0;
        tick(); tick();
        chk("t1_idle_all_end", {31'd0, all_end0}, 32'd0);

        // Literal then offset 1 with length 25: run of 26 identical bytes.
        clear(0);
        lit(0, 8'h61); off7(0, 1); lenc(0, 25); endm(0);
        upd();
        ce0 = 1'b1;
        wait_end0(100);
        chk("t2_nbytes", outq0.size(), 26);
        nbad = 0;
        foreach (outq0[i]) if (outq0[i] !== 8'h61) nbad++;
        chk("t2_bad_bytes", nbad, 0);
        exp2 = '{9, 9, 2, 2, 4, 4, 9};
        chk("t2_nacks", ackq0.size(), 7);
        for (int i = 0; i < ackq0.size() && i < 7; i++) chk("t2_width", ackq0[i], exp2[i]);
        chk("t2_byte_cnt", bc0, 32'd26);
        ce0 = 1'b0;
        tick(); tick();

        // "abc" + 11-bit offset 3 len 4 with out_ready toggling.
        clear(0);
        lit(0, 8'h61); lit(0, 8'h62); lit(0, 8'h63); off11(0, 3); lenc(0, 4); endm(0);
        upd();
        ce0 = 1'b1;
        for (int i = 0; i < 100 && !all_end0; i++) begin
            tick();
            if0.out_ready = ~if0.out_ready;
        end
        if0.out_ready = 1'b1;
        chk("t3_all_end", {31'd0, all_end0}, 32'd1);
        exp3 = '{8'h61, 8'h62, 8'h63, 8'h61, 8'h62, 8'h63, 8'h61};
        chk("t3_nbytes", outq0.size(), 7);
        for (int i = 0; i < outq0.size() && i < 7; i++)
            chk("t3_byte", {24'd0, outq0[i]}, {24'd0, exp3[i]});
        tick();
        chk("t3_byte_cnt", bc0, 32'd7);
        ce0 = 1'b0;
        tick(); tick();

        // Offset reaching past history raises err and stops consumption.
        clear(0);
        lit(0, 8'h78); lit(0, 8'h79); lit(0, 8'h7A); off7(0, 5); lenc(0, 2);
        lit(0, 8'h55); endm(0);
        upd();
        ce0 = 1'b1;
        for (int i = 0; i < 40 && !err0; i++) tick();
        chk("t4_err", {31'd0, err0}, 32'd1);
        nack = ackq0.size();
        repeat (10) tick();
        chk("t4_no_new_acks", ackq0.size() - nack, 0);
        chk("t4_nacks", ackq0.size(), 3);
        chk("t4_nbytes", outq0.size(), 3);
        for (int i = 0; i < outq0.size() && i < 3; i++)
            chk("t4_byte", {24'd0, outq0[i]}, 32'h78 + i);
        chk("t4_byte_cnt", bc0, 32'd3);
        chk("t4_err_sticky", {31'd0, err0}, 32'd1);
        ce0 = 1'b0;
        tick(); tick();

        // Reset in the middle of a length-20 copy.
        clear(0);
        lit(0, 8'h77); off7(0, 1); lenc(0, 20); endm(0);
        upd();
        ce0 = 1'b1;
        for (int i = 0; i < 60 && outq0.size() < 5; i++) tick();
        chk("t5_mid_copy_valid", {31'd0, if0.out_valid}, 32'd1);
        rst = 1'b1;
        ce0 = 1'b0;
        tick();
        chk("t5_rst_valid", {31'd0, if0.out_valid}, 32'd0);
        chk("t5_rst_ack", {31'd0, if0.stream_ack}, 32'd0);
        chk("t5_rst_byte_cnt", bc0, 32'd0);
        chk("t5_rst_all_end", {31'd0, all_end0}, 32'd0);
        rst = 1'b0;
        stalled0 = 1'b0;
        clear(0);
        lit(0, 8'h5A); lit(0, 8'h5B); endm(0);
        upd();
        tick();
        ce0 = 1'b1;
        wait_end0(40);
        chk("t5_nbytes", outq0.size(), 2);
        if (outq0.size() == 2) begin
            chk("t5_byte0", {24'd0, outq0[0]}, 32'h5A);
            chk("t5_byte1", {24'd0, outq0[1]}, 32'h5B);
        end
        ce0 = 1'b0;
        tick(); tick();
        clear(0);
        off7(0, 1); lenc(0, 2); endm(0);
        upd();
        ce0 = 1'b1;
        for (int i = 0; i < 20 && !err0; i++) tick();
        chk("t5_first_offset_err", {31'd0, err0}, 32'd1);
        chk("t5_err_nbytes", outq0.size(), 0);
        ce0 = 1'b0;
        tick(); tick();

        // 16-byte history: offset 16 valid, offset 17 errors.
        clear(1);
        for (int i = 0; i < 40; i++) lit(1, 8'(i + 1));
        off11(1, 16); lenc(1, 2);
        off11(1, 17); lenc(1, 2);
        endm(1);
        upd();
        ce1 = 1'b1;
        for (int i = 0; i < 300 && !err1; i++) tick();
        chk("t6_err", {31'd0, err1}, 32'd1);
        repeat (3) tick();
        chk("t6_nbytes", outq1.size(), 42);
        if (outq1.size() == 42) begin
            chk("t6_off16_a", {24'd0, outq1[40]}, 32'h19);
            chk("t6_off16_b", {24'd0, outq1[41]}, 32'h1A);
        end
        chk("t6_byte_cnt", bc1, 32'd42);
        ce1 = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
